// File: rtl/netlist_sequencer.sv
// Issues netlist gates in gid order to the garbling engine; descriptor appears 1 cycle after the CHECK decision, >=2 cycles/gate.
// Holds g_valid and g_* stable until g_ready; stalls in CHECK on unproduced inputs or MAX_INFLIGHT outstanding gates.
module netlist_sequencer #(
    parameter int S            = 20,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] num_gates,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [S-1:0] nl_gid,
    input  logic [S-1:0] nl_input_size,
    input  logic [S-1:0] nl_in0,
    input  logic [S-1:0] nl_in1,
    input  logic         nl_in0F,
    input  logic         nl_in1F,
    input  logic [3:0]   nl_g_logic,
    output logic         g_valid,
    input  logic         g_ready,
    output logic [S-1:0] g_gid,
    output logic [S-1:0] g_in0,
    output logic [S-1:0] g_in1,
    output logic         g_in0F,
    output logic         g_in1F,
    output logic [3:0]   g_logic,
    output logic [S-1:0] g_out_wire,
    input  logic         g_done
);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, DONE} state_t;

    localparam logic [S-1:0] ONE    = S'(1);
    localparam logic [S-1:0] MAX_IF = S'(MAX_INFLIGHT);

    state_t       state_q;
    logic [S-1:0] num_q, gid_q, issued_q, completed_q;
    logic         err_q, done_q, g_valid_q;
    logic [S-1:0] g_gid_q, g_in0_q, g_in1_q, g_out_wire_q;
    logic         g_in0F_q, g_in1F_q;
    logic [3:0]   g_logic_q;

    logic [S-1:0] out_wire_d, rel0, rel1, gid_inc_d;
    logic         in0_rdy, in1_rdy, slot_ok, fwd_ref, can_issue;
    logic         cmpl_inc, cmpl_err;

    always_comb begin
        out_wire_d = nl_input_size + gid_q;
        gid_inc_d  = gid_q + ONE;
        rel0       = nl_in0 - nl_input_size;
        rel1       = nl_in1 - nl_input_size;
        // A produced wire index below `completed` means its gate has already finished.
        in0_rdy    = nl_in0F || (rel0 < completed_q);
        in1_rdy    = nl_in1F || (rel1 < completed_q);
        slot_ok    = (issued_q - completed_q) < MAX_IF;
        fwd_ref    = (!nl_in0F && (nl_in0 >= out_wire_d)) ||
                     (!nl_in1F && (nl_in1 >= out_wire_d));
        can_issue  = in0_rdy && in1_rdy && slot_ok;
        cmpl_inc   = g_done && (state_q != IDLE) && (completed_q != issued_q);
        cmpl_err   = g_done && (state_q != IDLE) && (completed_q == issued_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            gid_q        <= '0;
            issued_q     <= '0;
            completed_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            g_valid_q    <= 1'b0;
            g_gid_q      <= '0;
            g_in0_q      <= '0;
            g_in1_q      <= '0;
            g_in0F_q     <= 1'b0;
            g_in1F_q     <= 1'b0;
            g_logic_q    <= '0;
            g_out_wire_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (cmpl_inc) completed_q <= completed_q + ONE;
            if (cmpl_err) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_q       <= num_gates;
                        gid_q       <= '0;
                        issued_q    <= '0;
                        completed_q <= '0;
                        err_q       <= 1'b0;
                        state_q     <= (num_gates == '0) ? DONE : CHECK;
                    end
                end
                CHECK: begin
                    if (fwd_ref) begin
                        err_q     <= 1'b1;
                        g_valid_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else if (can_issue) begin
                        g_gid_q      <= gid_q;
                        g_in0_q      <= nl_in0;
                        g_in1_q      <= nl_in1;
                        g_in0F_q     <= nl_in0F;
                        g_in1F_q     <= nl_in1F;
                        g_logic_q    <= nl_g_logic;
                        g_out_wire_q <= out_wire_d;
                        g_valid_q    <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (g_ready) begin
                        g_valid_q <= 1'b0;
                        issued_q  <= issued_q + ONE;
                        gid_q     <= gid_inc_d;
                        state_q   <= (gid_inc_d == num_q) ? DRAIN : CHECK;
                    end
                end
                DRAIN: begin
                    if (completed_q == issued_q) state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign nl_gid     = gid_q;
    assign g_valid    = g_valid_q;
    assign g_gid      = g_gid_q;
    assign g_in0      = g_in0_q;
    assign g_in1      = g_in1_q;
    assign g_in0F     = g_in0F_q;
    assign g_in1F     = g_in1F_q;
    assign g_logic    = g_logic_q;
    assign g_out_wire = g_out_wire_q;

endmodule

// File: tb/tb_netlist_sequencer.sv
// Randomized bench: ROM netlist + engine model with in-order completions; every issued gate is
// checked against the ROM, the dependency rule and the in-flight bound, plus directed corner cases.
module tb_netlist_sequencer;
    localparam int S    = 20;
    localparam int MAXF = 4;
    localparam int NG   = 64;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [S-1:0] num_gates = '0, nl_input_size = '0;
    logic [S-1:0] nl_gid, nl_in0, nl_in1;
    logic         nl_in0F, nl_in1F;
    logic [3:0]   nl_g_logic;
    logic         busy, done, err, g_valid, g_in0F, g_in1F;
    logic         g_ready = 1'b0, g_done = 1'b0;
    logic [S-1:0] g_gid, g_in0, g_in1, g_out_wire;
    logic [3:0]   g_logic;

    logic [S-1:0] rom_in0 [NG];
    logic [S-1:0] rom_in1 [NG];
    logic         rom_f0  [NG];
    logic         rom_f1  [NG];
    logic [3:0]   rom_lg  [NG];

    assign nl_in0     = rom_in0[nl_gid[5:0]];
    assign nl_in1     = rom_in1[nl_gid[5:0]];
    assign nl_in0F    = rom_f0[nl_gid[5:0]];
    assign nl_in1F    = rom_f1[nl_gid[5:0]];
    assign nl_g_logic = rom_lg[nl_gid[5:0]];

    netlist_sequencer #(.S(S), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_gates(num_gates),
        .busy(busy), .done(done), .err(err), .nl_gid(nl_gid),
        .nl_input_size(nl_input_size), .nl_in0(nl_in0), .nl_in1(nl_in1),
        .nl_in0F(nl_in0F), .nl_in1F(nl_in1F), .nl_g_logic(nl_g_logic),
        .g_valid(g_valid), .g_ready(g_ready), .g_gid(g_gid), .g_in0(g_in0),
        .g_in1(g_in1), .g_in0F(g_in0F), .g_in1F(g_in1F), .g_logic(g_logic),
        .g_out_wire(g_out_wire), .g_done(g_done)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_acc = 0, n_done_drv = 0, done_snap = 0, done_km1 = 0;
    int done_pulses = 0, exp_gid = 0, lim = 0, rise_cyc = 0;
    int ready_pct = 100, dly_max = 0;
    bit auto_done = 1'b1, force_done = 1'b0, prev_valid = 1'b0;
    int due_q[$];
    logic [S-1:0] cur_size = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_issue();
        int idx = exp_gid % NG;
        rise_cyc = cyc;
        chk("issue_in_range", exp_gid < lim, 1);
        chk("g_gid", g_gid, exp_gid);
        chk("g_in0", g_in0, rom_in0[idx]);
        chk("g_in1", g_in1, rom_in1[idx]);
        chk("g_in0F", g_in0F, rom_f0[idx]);
        chk("g_in1F", g_in1F, rom_f1[idx]);
        chk("g_logic", g_logic, rom_lg[idx]);
        chk("g_out_wire", g_out_wire, (int'(cur_size) + exp_gid) % (1 << S));
        chk("inflight_bound", (n_acc - done_km1) < MAXF, 1);
        if (!rom_f0[idx]) chk("dep_in0", (int'(rom_in0[idx]) - int'(cur_size)) < done_km1, 1);
        if (!rom_f1[idx]) chk("dep_in1", (int'(rom_in1[idx]) - int'(cur_size)) < done_km1, 1);
    endtask

    // One clock: observe just after the edge, then drive the engine inputs for the next edge.
    task automatic step();
        int d;
        @(posedge clk);
        #1;
        cyc++;
        done_km1  = done_snap;
        done_snap = n_done_drv;
        if (done) begin
            done_pulses++;
            chk("drain_empty", due_q.size(), 0);
        end
        if (g_valid && !prev_valid) check_issue();
        prev_valid = g_valid;
        if (g_valid) g_ready = ($urandom_range(99) < ready_pct);
        else         g_ready = 1'($urandom_range(1));
        if (g_valid && g_ready) begin
            d = cyc + 1 + $urandom_range(dly_max);
            if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
            due_q.push_back(d);
            n_acc++;
            exp_gid++;
        end
        g_done = 1'b0;
        if (force_done || (auto_done && due_q.size() > 0 && due_q[0] <= cyc)) begin
            g_done = 1'b1;
            n_done_drv++;
            if (due_q.size() > 0) void'(due_q.pop_front());
            force_done = 1'b0;
        end
    endtask

    task automatic build_rom(input int ng, input int size, input int fwd_at, input int dep_pct);
        cur_size = S'(size);
        for (int g = 0; g < NG; g++) begin
            rom_lg[g] = 4'($urandom);
            for (int k = 0; k < 2; k++) begin
                logic         f;
                logic [S-1:0] w;
                if (g > 0 && g < ng && $urandom_range(99) < dep_pct) begin
                    f = 1'b0;
                    w = S'(size + int'($urandom_range(g - 1)));
                end else begin
                    f = 1'b1;
                    w = S'($urandom_range(size - 1));
                end
                if (k == 0) begin rom_f0[g] = f; rom_in0[g] = w; end
                else        begin rom_f1[g] = f; rom_in1[g] = w; end
            end
        end
        if (fwd_at >= 0) begin
            rom_f1[fwd_at]  = 1'b0;
            rom_in1[fwd_at] = S'(size + fwd_at + int'($urandom_range(3)));
        end
    endtask

    task automatic hard_reset();
        rst_n = 1'b0; start = 1'b0; g_ready = 1'b0; g_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        due_q.delete();
        prev_valid = 1'b0;
        force_done = 1'b0;
    endtask

    task automatic begin_run(input int ng, input int exp_lim);
        lim = exp_lim; exp_gid = 0; n_acc = 0; n_done_drv = 0;
        done_snap = 0; done_km1 = 0; done_pulses = 0; prev_valid = 1'b0;
        due_q.delete();
        nl_input_size = cur_size;
        num_gates = S'(ng);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_run(input bit exp_err);
        int t = 0;
        while (done_pulses == 0 && t < 3000) begin
            step();
            t++;
        end
        if (done_pulses == 0) begin
            chk("done_timeout", 0, 1);
            hard_reset();
        end else begin
            chk("issued_count", n_acc, lim);
            chk("err_at_done", err, exp_err);
            chk("busy_at_done", busy, 0);
            repeat (3) step();
            chk("single_done_pulse", done_pulses, 1);
        end
    endtask

    initial begin
        int t, kd, ng, fwd;
        for (int g = 0; g < NG; g++) begin
            rom_in0[g] = '0; rom_in1[g] = '0; rom_f0[g] = 1'b1; rom_f1[g] = 1'b1; rom_lg[g] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", g_valid, 0);
        chk("rst_nl_gid", nl_gid, 0);
        chk("rst_g_gid", g_gid, 0);
        chk("rst_out_wire", g_out_wire, 0);
        rst_n = 1'b1;

        // Empty run: busy for one cycle, done two cycles after start.
        build_rom(0, 22, -1, 0);
        begin_run(0, 0);
        chk("zero_busy_c1", busy, 1);
        chk("zero_done_c1", done, 0);
        step();
        chk("zero_busy_c2", busy, 0);
        chk("zero_done_c2", done, 1);
        step();
        chk("zero_done_c3", done, 0);
        chk("zero_no_issue", n_acc, 0);

        // Three independent gates, ready always, completion one cycle after accept.
        build_rom(3, 22, -1, 0);
        ready_pct = 100; dly_max = 0; auto_done = 1'b1;
        begin_run(3, 3);
        finish_run(1'b0);

        // Gate 1 consumes gate 0's output; gate 0 completes late.
        build_rom(2, 22, -1, 0);
        rom_f0[1] = 1'b0; rom_in0[1] = S'(22);
        auto_done = 1'b0;
        begin_run(2, 2);
        t = 0;
        while (n_acc == 0 && t < 50) begin step(); t++; end
        chk("dep_first_accept", n_acc, 1);
        repeat (10) begin
            step();
            chk("dep_stall", g_valid, 0);
        end
        force_done = 1'b1;
        step();
        kd = cyc + 1;
        step();
        chk("dep_low_on_done_cycle", g_valid, 0);
        step();
        chk("dep_issue", g_valid, 1);
        chk("dep_rise_cycle", rise_cyc, kd + 1);
        auto_done = 1'b1;
        finish_run(1'b0);

        // In-flight cap: completions withheld.
        build_rom(6, 22, -1, 0);
        auto_done = 1'b0;
        begin_run(6, 6);
        repeat (30) step();
        chk("inflight_cap", n_acc, MAXF);
        chk("inflight_stall", g_valid, 0);
        force_done = 1'b1;
        repeat (6) step();
        chk("inflight_release", n_acc, MAXF + 1);
        auto_done = 1'b1;
        finish_run(1'b0);

        // Forward reference at gate 2, then a stray completion.
        build_rom(3, 22, -1, 0);
        rom_f1[2] = 1'b0; rom_in1[2] = S'(25);
        dly_max = 3;
        begin_run(3, 2);
        finish_run(1'b1);
        force_done = 1'b1;
        step();
        step();
        chk("err_after_stray", err, 1);

        // Asynchronous reset while a descriptor is waiting for ready.
        build_rom(4, 22, -1, 0);
        ready_pct = 0;
        begin_run(4, 4);
        t = 0;
        while (!g_valid && t < 20) begin step(); t++; end
        chk("rst_mid_issue_reached", g_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", g_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        hard_reset();
        ready_pct = 100;

        for (int r = 0; r < 25; r++) begin
            ng  = int'($urandom_range(1, 40));
            fwd = ($urandom_range(3) == 0) ? int'($urandom_range(ng - 1)) : -1;
            ready_pct = int'($urandom_range(30, 100));
            dly_max   = int'($urandom_range(8));
            auto_done = 1'b1;
            build_rom(ng, int'($urandom_range(1, 5000)), fwd, 50);
            begin_run(ng, (fwd >= 0) ? fwd : ng);
            finish_run(fwd >= 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
